alu_instr_issue: RTL
====================

Name: alu_instr_issue

Overview:
Instruction-decode and issue sequencer that drives the RegFile_Alu control interface from encoded 16-bit ALU instruction words. It accepts instructions over a valid/ready handshake and decodes them into RdestRegLoc, RsrcRegLoc, Imm_s, Imm, OpCode and a one-cycle En strobe. It then captures the resulting RdestOut and Flags and returns them over a valid/ready response handshake. It replaces hand-driven stimulus as the initiator of RegFile_Alu and sits between the instruction source and RegFile_Alu.

Parameters:
OP_MAX, 9, highest legal ALU opcode (ADD=0 … ARSH=9); opcodes above it are illegal.
CNT_W, 8, width of the issued-instruction counter.

Ports:
Clk  in  1  system clock, rising edge.
Rst  in  1  asynchronous active-low reset.
Instr  in  16  instruction word.
InstrValid  in  1  Instr is valid.
InstrReady  out  1  block can accept Instr.
RdestRegLoc  out  4  destination/first-operand register to RegFile_Alu.
RsrcRegLoc  out  4  source register to RegFile_Alu.
Imm  out  16  sign-extended immediate to RegFile_Alu.
Imm_s  out  1  select Imm instead of Rsrc.
OpCode  out  5  ALU opcode to RegFile_Alu; bit 4 always 0.
En  out  1  RegFile_Alu write enable, one-cycle strobe.
RdestOut  in  16  result from RegFile_Alu.
Flags  in  5  flags from RegFile_Alu.
RspData  out  16  captured result.
RspFlags  out  5  captured flags.
RspErr  out  1  instruction was illegal, not issued.
RspValid  out  1  response valid.
RspReady  in  1  response consumer ready.
IssueCount  out  CNT_W  count of legal instructions issued, wraps.

Behaviour:
- Encoding: Instr[15]=Imm_s; Instr[14:11]=opcode; Instr[10:7]=Rdest.
- Imm_s=0: Instr[6:3]=Rsrc; Instr[2:0] ignored.
- Imm_s=1: Instr[6:0]=imm7, sign-extended to 16 bits on Imm; RsrcRegLoc=0.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: InstrReady=1. On a rising edge with InstrValid=1, register the decoded fields.
  - Legal opcode (opcode ≤ OP_MAX) → ISSUE.
  - Illegal opcode → RESP with RspErr=1, RspData=0, RspFlags=0. En is never asserted and IssueCount does not change.
- ISSUE: En=1 for exactly this cycle; IssueCount increments at the exiting edge; → WAIT.
- WAIT: En=0. At the exiting edge, capture RdestOut→RspData and Flags→RspFlags, set RspErr=0; → RESP.
- RESP: RspValid=1. RspData, RspFlags and RspErr hold stable until RspValid&&RspReady at a rising edge; → IDLE.
- Latency: the accept edge is E0. En is high between E0 and E1. RegFile writes at E1. Capture is at E2, and RspValid is high after E2.
- Throughput: one instruction per 4 cycles minimum with RspReady held high.
- InstrReady=0 in every state except IDLE; Instr is ignored when InstrReady=0.
- Decoded drive signals (RdestRegLoc, RsrcRegLoc, Imm, Imm_s, OpCode) are registered. They hold their last value outside ISSUE so RdestOut stays observable.
- RspReady asserted outside RESP has no effect. InstrValid may stay high across instructions; each acceptance in IDLE is a new instruction.
- IssueCount wraps from 2^CNT_W-1 to 0.
- Reset (Rst=0, asynchronous, any state, including mid-ISSUE) sets:
  - state=IDLE, En=0, RspValid=0, RspErr=0.
  - RspData=0, RspFlags=0, IssueCount=0.
  - RdestRegLoc=0, RsrcRegLoc=0, Imm=0, Imm_s=0, OpCode=0.
  - InstrReady=1 from the first edge after Rst deasserts. Any in-flight instruction is dropped with no response.

Test Plan:
- Reset RegFile and block, send 16'h8001 (ADD r0,#1) → En high exactly one cycle with RdestRegLoc=0, Imm_s=1, Imm=16'h0001, OpCode=0. RspValid 2 cycles after accept with RspData=1, RspErr=0, IssueCount=1.
- Send 16'h807F (ADD r0,#-1) after r0=1 → Imm=16'hFFFF, RspData=0, RspFlags equals Flags sampled at capture.
- With r0=1, issue 16'h0000|(i<<7) (ADD ri,r0) for i=1..15 → each RspData=1, IssueCount=16 at end.
- With r0=1, send 16'h3800 (LSH r0) 15 times with RspReady=1 → RspData=2,4,…,16'h8000. Accepts are spaced exactly 4 cycles apart.
- Send 16'h5000 (opcode 10) → no En pulse, RspValid with RspErr=1, RspData=0, IssueCount unchanged. Hold RspReady=0 for 5 cycles → response stable and InstrReady=0 throughout.
- Pull Rst low during ISSUE → En drops immediately, RspValid never asserts, IssueCount=0. A fresh 16'h8001 afterwards completes normally.

Source files
------------

// File: rtl/alu_instr_issue_if.sv
// rtl/alu_instr_issue_if.sv - instruction request / result response handshake bundle for alu_instr_issue
//
// Groups the two valid/ready channels between an instruction source and the
// issue sequencer.
//   Instr/InstrValid/InstrReady          : 16-bit encoded ALU instruction in
//   RspData/RspFlags/RspErr/RspValid/RspReady : captured result out
// master : the instruction source / response consumer
// slave  : the issue sequencer
interface alu_instr_issue_if;
    logic [15:0] Instr;
    logic        InstrValid;
    logic        InstrReady;
    logic [15:0] RspData;
    logic [4:0]  RspFlags;
    logic        RspErr;
    logic        RspValid;
    logic        RspReady;

    modport master (
        output Instr,
        output InstrValid,
        input  InstrReady,
        input  RspData,
        input  RspFlags,
        input  RspErr,
        input  RspValid,
        output RspReady
    );

    modport slave (
        input  Instr,
        input  InstrValid,
        output InstrReady,
        output RspData,
        output RspFlags,
        output RspErr,
        output RspValid,
        input  RspReady
    );
endinterface

// File: rtl/alu_instr_issue.sv
// rtl/alu_instr_issue.sv - decode 16-bit ALU instructions, strobe RegFile_Alu, return result and flags
//
// Purpose:
//   Accepts one encoded instruction at a time, drives the RegFile_Alu control
//   fields with a single-cycle En strobe, captures the resulting RdestOut and
//   Flags one cycle after the write, and returns them over a response
//   handshake. Illegal opcodes are answered with RspErr=1 and never issued.
//
//   Instruction word:
//     [15]    Imm_s
//     [14:11] opcode
//     [10:7]  Rdest
//     [6:3]   Rsrc    (Imm_s=0; [2:0] unused)
//     [6:0]   imm7    (Imm_s=1; sign-extended, Rsrc forced to 0)
//
// Ports:
//   Clk, Rst        clock (rising edge), asynchronous active-low reset
//   bus             instruction in / response out handshakes (slave side)
//   RdestRegLoc     destination / first-operand register
//   RsrcRegLoc      source register
//   Imm, Imm_s      sign-extended immediate and its select
//   OpCode          ALU opcode, bit 4 always 0
//   En              RegFile_Alu write strobe, one cycle per legal instruction
//   RdestOut, Flags result and flags returned by RegFile_Alu
//   IssueCount      wrapping count of legal instructions issued
module alu_instr_issue #(
    parameter int OP_MAX = 9,
    parameter int CNT_W  = 8
) (
    input  logic              Clk,
    input  logic              Rst,
    alu_instr_issue_if.slave  bus,
    output logic [3:0]        RdestRegLoc,
    output logic [3:0]        RsrcRegLoc,
    output logic [15:0]       Imm,
    output logic              Imm_s,
    output logic [4:0]        OpCode,
    output logic              En,
    input  logic [15:0]       RdestOut,
    input  logic [4:0]        Flags,
    output logic [CNT_W-1:0]  IssueCount
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    // Field extraction from the incoming word
    logic        dec_imm_s;
    logic [3:0]  dec_op;
    logic [3:0]  dec_rdest;
    logic [3:0]  dec_rsrc;
    logic [15:0] dec_imm;
    logic        dec_legal;
    logic        accept;

    // Registered drive and response state
    logic [3:0]       rdest_q;
    logic [3:0]       rsrc_q;
    logic [15:0]      imm_q;
    logic             imm_s_q;
    logic [3:0]       op_q;
    logic [15:0]      rsp_data_q;
    logic [4:0]       rsp_flags_q;
    logic             rsp_err_q;
    logic [CNT_W-1:0] issue_count_q;

    // Handshake / strobe outputs decoded from state
    logic instr_ready;
    logic rsp_valid;
    logic en;

    assign dec_imm_s = bus.Instr[15];
    assign dec_op    = bus.Instr[14:11];
    assign dec_rdest = bus.Instr[10:7];
    assign dec_rsrc  = dec_imm_s ? 4'd0 : bus.Instr[6:3];
    assign dec_imm   = dec_imm_s ? {{9{bus.Instr[6]}}, bus.Instr[6:0]} : 16'd0;
    assign dec_legal = (int'(dec_op) <= OP_MAX);

    assign accept = instr_ready && bus.InstrValid;

    // Next state and state-decoded outputs
    always_comb begin
        state_d     = state_q;
        instr_ready = 1'b0;
        rsp_valid   = 1'b0;
        en          = 1'b0;
        case (state_q)
            IDLE: begin
                instr_ready = 1'b1;
                if (bus.InstrValid) begin
                    state_d = dec_legal ? ISSUE : RESP;
                end
            end
            ISSUE: begin
                en      = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                state_d = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (bus.RspReady) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Drive fields are loaded only on acceptance and otherwise hold, so the
    // addressed register stays visible on RdestOut through WAIT and RESP.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            rdest_q <= 4'd0;
            rsrc_q  <= 4'd0;
            imm_q   <= 16'd0;
            imm_s_q <= 1'b0;
            op_q    <= 4'd0;
        end else if (accept) begin
            rdest_q <= dec_rdest;
            rsrc_q  <= dec_rsrc;
            imm_q   <= dec_imm;
            imm_s_q <= dec_imm_s;
            op_q    <= dec_op;
        end
    end

    // Response capture: illegal instructions answer straight from IDLE with a
    // zeroed payload; legal ones sample RegFile_Alu one cycle after the write.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            rsp_data_q  <= 16'd0;
            rsp_flags_q <= 5'd0;
            rsp_err_q   <= 1'b0;
        end else if (accept && !dec_legal) begin
            rsp_data_q  <= 16'd0;
            rsp_flags_q <= 5'd0;
            rsp_err_q   <= 1'b1;
        end else if (state_q == WAIT) begin
            rsp_data_q  <= RdestOut;
            rsp_flags_q <= Flags;
            rsp_err_q   <= 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            issue_count_q <= '0;
        end else if (state_q == ISSUE) begin
            issue_count_q <= issue_count_q + CNT_W'(1);
        end
    end

    assign RdestRegLoc = rdest_q;
    assign RsrcRegLoc  = rsrc_q;
    assign Imm         = imm_q;
    assign Imm_s       = imm_s_q;
    assign OpCode      = {1'b0, op_q};
    assign En          = en;
    assign IssueCount  = issue_count_q;

    assign bus.InstrReady = instr_ready;
    assign bus.RspValid   = rsp_valid;
    assign bus.RspData    = rsp_data_q;
    assign bus.RspFlags   = rsp_flags_q;
    assign bus.RspErr     = rsp_err_q;

endmodule
